// File: rtl/golden_report_pkg.sv
// Shared types and framing helpers for the golden nonce reporter.
package golden_report_pkg;

    localparam int FRAME_BYTES = 7;
    localparam int SEQ_W       = 8;
    localparam int DROP_W      = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [31:0]      nonce;
    } report_entry_t;

    // Byte idx of the 7-byte frame: sync, seq, nonce big-endian, xor checksum.
    function automatic logic [7:0] frame_byte(input report_entry_t entry,
                                              input logic [2:0]    idx,
                                              input logic [7:0]    sync);
        logic [7:0] chk;
        logic [7:0] b;
        chk = sync ^ entry.seq ^ entry.nonce[31:24] ^ entry.nonce[23:16]
              ^ entry.nonce[15:8] ^ entry.nonce[7:0];
        case (idx)
            3'd0:    b = sync;
            3'd1:    b = entry.seq;
            3'd2:    b = entry.nonce[31:24];
            3'd3:    b = entry.nonce[23:16];
            3'd4:    b = entry.nonce[15:8];
            3'd5:    b = entry.nonce[7:0];
            default: b = chk;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO of report entries; push while full is honoured when a pop
// happens in the same cycle.
module nonce_fifo
    import golden_report_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  report_entry_t            wr_entry,
    input  logic                     pop,
    output report_entry_t            rd_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    report_entry_t  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign rd_entry = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/golden_nonce_reporter.sv
// Detects new non-zero golden nonces, queues them and streams each one as a
// 7-byte frame over a valid/ready byte interface.
//   state | meaning
//   IDLE  | no frame in flight; pops the FIFO head when one is queued
//   SEND  | presenting frame byte idx, advancing on each handshake
module golden_nonce_reporter
    import golden_report_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [31:0]                    golden_nonce_in,
    output logic [7:0]                     tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic [DROP_W-1:0]              drop_count,
    output logic                           busy
);

    state_t           state;
    logic [31:0]      prev_nonce;
    logic [SEQ_W-1:0] seq;
    report_entry_t    frame;
    logic [2:0]       idx;

    logic             find;
    logic             pop;
    logic             push_ok;
    logic             full;
    logic             empty;
    logic             last_hs;
    report_entry_t    wr_entry;
    report_entry_t    head;

    assign find     = (golden_nonce_in != prev_nonce) && (golden_nonce_in != '0);
    assign pop      = (state == IDLE) && !empty;
    assign push_ok  = find && (!full || pop);
    assign wr_entry = '{seq: seq, nonce: golden_nonce_in};
    assign last_hs  = tx_valid && tx_ready && (idx == 3'(FRAME_BYTES-1));
    assign busy     = (state == SEND) || !empty;

    nonce_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_ok),
        .wr_entry (wr_entry),
        .pop      (pop),
        .rd_entry (head),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_nonce <= '0;
            seq        <= '0;
            drop_count <= '0;
        end else begin
            prev_nonce <= golden_nonce_in;
            if (push_ok) begin
                seq <= seq + 1'b1;
            end else if (find && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            frame    <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        frame    <= head;
                        idx      <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= SYNC_BYTE;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (last_hs) begin
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                        state    <= IDLE;
                    end else if (tx_ready) begin
                        idx     <= idx + 1'b1;
                        tx_data <= frame_byte(frame, idx + 3'd1, SYNC_BYTE);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Self-checking bench: expected frame bytes are queued when nonces are driven
// and compared as the DUT hands them over.
module tb_golden_nonce_reporter;

    logic        clk;
    logic        rst_n;
    logic [31:0] golden_nonce_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  fifo_count;
    logic [15:0] drop_count;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_seq;
    int         hs_count = 0;
    logic       stall = 1'b0;
    logic [7:0] stall_data = '0;
    int         frame_pos = 0;

    typedef struct {
        logic [31:0] nonce;
        logic [7:0]  seq;
        logic [7:0]  chk;
    } vec_t;
    vec_t vecs[4];

    golden_nonce_reporter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .golden_nonce_in (golden_nonce_in),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .fifo_count      (fifo_count),
        .drop_count      (drop_count),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] model_chk(input logic [7:0] s, input logic [31:0] n);
        return 8'hA5 ^ s ^ n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
    endfunction

    task automatic push_frame(input logic [7:0] s, input logic [31:0] n, input logic [7:0] chk);
        exp_q.push_back(8'hA5);
        exp_q.push_back(s);
        exp_q.push_back(n[31:24]);
        exp_q.push_back(n[23:16]);
        exp_q.push_back(n[15:8]);
        exp_q.push_back(n[7:0]);
        exp_q.push_back(chk);
    endtask

    task automatic send_model(input logic [31:0] n);
        golden_nonce_in = n;
        push_frame(exp_seq, n, model_chk(exp_seq, n));
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        bit done = 0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            if (!busy && !tx_valid && exp_q.size() == 0) done = 1;
        end
        check({name, "_drain"}, {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        golden_nonce_in = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_seq = 8'h00;
    endtask

    // Byte scoreboard plus stream-rule checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
            frame_pos = 0;
        end else begin
            if (stall) begin
                check("stall_valid", {31'd0, tx_valid}, 32'd1);
                check("stall_data", {24'd0, tx_data}, {24'd0, stall_data});
            end
            if (frame_pos != 0 && !tx_valid)
                check("valid_mid_frame", 32'd0, 32'd1);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("frame_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
                hs_count++;
                frame_pos = (frame_pos == 6) ? 0 : frame_pos + 1;
            end
            stall = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    initial begin
        int valid_seen;
        int gaps;
        int base;
        bit ok;
        int peak;

        vecs[0] = '{nonce: 32'h0000_5302, seq: 8'h00, chk: 8'hF4};
        vecs[1] = '{nonce: 32'hDEAD_BEEF, seq: 8'h01, chk: 8'h86};
        vecs[2] = '{nonce: 32'h1234_5678, seq: 8'h02, chk: 8'hAF};
        vecs[3] = '{nonce: 32'hFFFF_FFFF, seq: 8'h03, chk: 8'hA6};

        rst_n = 1'b0;
        tx_ready = 1'b1;
        golden_nonce_in = '0;
        exp_seq = 8'h00;
        #3;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        check("rst_drop_count", {16'd0, drop_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table: single finds with hand-computed checksums and latency checks.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            golden_nonce_in = vecs[i].nonce;
            push_frame(vecs[i].seq, vecs[i].nonce, vecs[i].chk);
            @(posedge clk); #1;
            check("lat_push_valid", {31'd0, tx_valid}, 32'd0);
            check("lat_push_count", {29'd0, fifo_count}, 32'd1);
            check("lat_push_busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
            check("lat_first_valid", {31'd0, tx_valid}, 32'd1);
            check("lat_first_data", {24'd0, tx_data}, 32'h0000_00A5);
            check("lat_count_after_pop", {29'd0, fifo_count}, 32'd0);
            wait_idle("table", 40);
        end
        exp_seq = 8'h04;
        valid_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_valid) valid_seen++;
        end
        check("held_no_refire", valid_seen, 0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Backpressure with a 1,0,0,1 ready pattern.
        @(posedge clk); #1;
        send_model(32'h0000_5302);
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(posedge clk); #1;
            tx_ready = (i % 4 == 0) || (i % 4 == 3);
            if (!busy && !tx_valid && exp_q.size() == 0) ok = 1;
        end
        check("backpressure_drain", {31'd0, ok}, 32'd1);
        tx_ready = 1'b1;

        // Back-to-back frames, one bubble cycle between them.
        do_reset();
        @(posedge clk); #1;
        golden_nonce_in = 32'h10;
        push_frame(8'h00, 32'h10, 8'hB5);
        @(posedge clk); #1;
        golden_nonce_in = 32'h20;
        push_frame(8'h01, 32'h20, 8'h84);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (tx_valid) ok = 1;
        end
        check("b2b_start", {31'd0, ok}, 32'd1);
        gaps = 0;
        for (int i = 0; i < 15; i++) begin
            if (i != 0) @(negedge clk);
            if (!tx_valid) gaps++;
        end
        check("b2b_bubble", gaps, 1);
        wait_idle("b2b", 20);

        // Overflow: six finds while the consumer is stalled.
        do_reset();
        tx_ready = 1'b0;
        peak = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (fifo_count > peak) peak = fifo_count;
            if (k <= 5) send_model(32'(k));
            else golden_nonce_in = 32'd6;
        end
        @(posedge clk); #1;
        if (fifo_count > peak) peak = fifo_count;
        check("ovf_count", {29'd0, fifo_count}, 32'd4);
        check("ovf_drop", {16'd0, drop_count}, 32'd1);
        check("ovf_peak", peak, 4);
        tx_ready = 1'b1;
        wait_idle("ovf", 80);
        check("ovf_drop_after", {16'd0, drop_count}, 32'd1);

        // Reset in the middle of a frame with another entry queued.
        @(posedge clk); #1;
        send_model(32'hCAFE_0001);
        @(posedge clk); #1;
        send_model(32'hCAFE_0002);
        base = hs_count;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            if (hs_count - base >= 4) ok = 1;
        end
        check("mid_reach_byte3", {31'd0, ok}, 32'd1);
        #1;
        check("mid_queued", {29'd0, fifo_count}, 32'd1);
        rst_n = 1'b0;
        golden_nonce_in = '0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        check("mid_rst_drop", {16'd0, drop_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_seq = 8'h00;
        @(posedge clk); #1;
        send_model(32'h0BAD_F00D);
        wait_idle("post_reset", 40);
        check("post_reset_seq", {24'd0, exp_seq}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
